// File: rtl/jvm_fetch_sequencer_if.sv
// IRAM byte-request handshake between the fetch sequencer (master) and instruction RAM (slave).
interface jvm_fetch_sequencer_if;
    logic [7:0] iram_data;
    logic       iram_valid;
    logic       iram_req;

    modport master (
        output iram_req,
        input  iram_data,
        input  iram_valid
    );

    modport slave (
        input  iram_req,
        output iram_data,
        output iram_valid
    );
endinterface

// File: rtl/jvm_fetch_sequencer.sv
// JVM front-end sequencer: opcode fetch with WIDE prefix, operand walk, micro-op chain stepping.
// Optional operand capture register is built when SM_PARAM_CAPTURE_EN is defined.
module jvm_fetch_sequencer #(
    parameter int unsigned ADR_W     = 8,
    parameter int unsigned PARAM_LEN = 3,
    parameter int unsigned MAX_BYTES = 8,
    parameter logic [7:0]  WIDE_OP   = 8'hC4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   waiting,
    jvm_fetch_sequencer_if.master  iram,
    input  logic [PARAM_LEN-1:0]   parameter_number,
    input  logic [ADR_W-1:0]       next_adr,
    input  logic                   iter_ready,
    output logic [1:0]             state,
    output logic [ADR_W-1:0]       com_adr,
    output logic [7:0]             jvm_opcode,
    output logic                   q_select,
    output logic                   param_even,
    output logic                   push_wide,
    output logic                   is_wide,
    output logic                   instr_done,
    output logic [8*MAX_BYTES-1:0] param_data
);

    localparam int unsigned CntW = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StDecode  = 2'd1,
        StParams  = 2'd2,
        StIterate = 2'd3
    } state_e;

    state_e           state_q;
    logic [ADR_W-1:0] com_adr_q;
    logic [7:0]       opcode_q;
    logic             q_select_q;
    logic             param_even_q;
    logic             push_wide_q;
    logic             is_wide_q;
    logic             instr_done_q;
    logic [CntW-1:0]  counter_q;
    logic [CntW-1:0]  total_q;

    logic [PARAM_LEN:0] shifted;
    logic [CntW-1:0]    total_calc;
    logic               bytes_left;
    logic               byte_ack;

    // Operand count doubles once under WIDE and saturates so the counter never wraps.
    always_comb begin
        shifted = is_wide_q ? {parameter_number, 1'b0} : {1'b0, parameter_number};
        if (32'(shifted) > MAX_BYTES) begin
            total_calc = CntW'(MAX_BYTES);
        end else begin
            total_calc = CntW'(shifted);
        end
    end

    assign bytes_left = (counter_q < total_q);
    assign byte_ack   = (state_q == StParams) && bytes_left && !param_even_q && iram.iram_valid;

    assign iram.iram_req = reset && !waiting &&
                           ((state_q == StFetch) ||
                            ((state_q == StParams) && bytes_left && !param_even_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StFetch;
            com_adr_q    <= '0;
            opcode_q     <= '0;
            q_select_q   <= 1'b0;
            param_even_q <= 1'b0;
            push_wide_q  <= 1'b0;
            is_wide_q    <= 1'b0;
            instr_done_q <= 1'b0;
            counter_q    <= '0;
            total_q      <= '0;
        end else if (!waiting) begin
            push_wide_q  <= 1'b0;
            instr_done_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (iram.iram_valid) begin
                        opcode_q <= iram.iram_data;
                        state_q  <= StDecode;
                    end
                end
                StDecode: begin
                    counter_q <= '0;
                    total_q   <= total_calc;
                    if (opcode_q == WIDE_OP) begin
                        is_wide_q <= 1'b1;
                        state_q   <= StFetch;
                    end else if (total_calc != '0) begin
                        q_select_q <= 1'b0;
                        state_q    <= StParams;
                    end else begin
                        com_adr_q  <= ADR_W'(opcode_q);
                        q_select_q <= 1'b1;
                        is_wide_q  <= 1'b0;
                        state_q    <= StIterate;
                    end
                end
                StParams: begin
                    if (bytes_left) begin
                        // Accept phase then advance phase: every operand byte costs two cycles.
                        if (!param_even_q) begin
                            if (iram.iram_valid) begin
                                param_even_q <= 1'b1;
                            end
                        end else begin
                            counter_q    <= counter_q + CntW'(1);
                            param_even_q <= 1'b0;
                        end
                    end else begin
                        push_wide_q  <= 1'b1;
                        com_adr_q    <= ADR_W'(opcode_q);
                        q_select_q   <= 1'b1;
                        param_even_q <= 1'b0;
                        is_wide_q    <= 1'b0;
                        state_q      <= StIterate;
                    end
                end
                StIterate: begin
                    is_wide_q <= 1'b0;
                    if (iter_ready) begin
                        if (next_adr == '0) begin
                            instr_done_q <= 1'b1;
                            q_select_q   <= 1'b0;
                            state_q      <= StFetch;
                        end else begin
                            com_adr_q <= next_adr;
                        end
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

`ifdef SM_PARAM_CAPTURE_EN
    logic [8*MAX_BYTES-1:0] param_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            param_q <= '0;
        end else if (!waiting) begin
            if (state_q == StDecode) begin
                param_q <= '0;
            end else if (byte_ack) begin
                param_q <= {param_q[8*MAX_BYTES-9:0], iram.iram_data};
            end
        end
    end

    assign param_data = param_q;
`else
    logic unused_byte_ack;
    assign unused_byte_ack = byte_ack;
    assign param_data      = '0;
`endif

    assign state      = state_q;
    assign com_adr    = com_adr_q;
    assign jvm_opcode = opcode_q;
    assign q_select   = q_select_q;
    assign param_even = param_even_q;
    assign push_wide  = push_wide_q;
    assign is_wide    = is_wide_q;
    assign instr_done = instr_done_q;

endmodule

// File: tb/tb_jvm_fetch_sequencer.sv
// Directed self-checking bench for jvm_fetch_sequencer with a small opcode table and next-address ROM.
module tb_jvm_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        waiting;
    logic [2:0]  parameter_number;
    logic [7:0]  next_adr;
    logic        iter_ready;
    logic [1:0]  state;
    logic [7:0]  com_adr;
    logic [7:0]  jvm_opcode;
    logic        q_select;
    logic        param_even;
    logic        push_wide;
    logic        is_wide;
    logic        instr_done;
    logic [63:0] param_data;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int acc_base = 0;

    jvm_fetch_sequencer_if bus ();

    jvm_fetch_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .waiting          (waiting),
        .iram             (bus),
        .parameter_number (parameter_number),
        .next_adr         (next_adr),
        .iter_ready       (iter_ready),
        .state            (state),
        .com_adr          (com_adr),
        .jvm_opcode       (jvm_opcode),
        .q_select         (q_select),
        .param_even       (param_even),
        .push_wide        (push_wide),
        .is_wide          (is_wide),
        .instr_done       (instr_done),
        .param_data       (param_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] param_lut(input logic [7:0] op);
        case (op)
            8'h10:   return 3'd1;
            8'h15:   return 3'd1;
            8'h30:   return 3'd7;
            8'h40:   return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] rom(input logic [7:0] adr);
        case (adr)
            8'h10:   return 8'h55;
            8'h15:   return 8'h66;
            8'h20:   return 8'h21;
            8'h21:   return 8'h22;
            default: return 8'h00;
        endcase
    endfunction

    assign parameter_number = param_lut(jvm_opcode);
    assign next_adr         = rom(com_adr);

    always @(posedge clk) begin
        if (bus.iram_req && bus.iram_valid) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.iram_valid = v;
        bus.iram_data  = d;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".state"}, 64'(state), 64'd0);
        chk({tag, ".com_adr"}, 64'(com_adr), 64'd0);
        chk({tag, ".opcode"}, 64'(jvm_opcode), 64'd0);
        chk({tag, ".q_select"}, 64'(q_select), 64'd0);
        chk({tag, ".param_even"}, 64'(param_even), 64'd0);
        chk({tag, ".push_wide"}, 64'(push_wide), 64'd0);
        chk({tag, ".is_wide"}, 64'(is_wide), 64'd0);
        chk({tag, ".instr_done"}, 64'(instr_done), 64'd0);
        chk({tag, ".param_data"}, param_data, 64'd0);
        chk({tag, ".iram_req"}, 64'(bus.iram_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        waiting    = 1'b0;
        iter_ready = 1'b0;
        drive(1'b0, 8'h00);
        tick();
        tick();
        chk_idle("por");
        reset = 1'b1;
        #1;
        chk("rel.iram_req", 64'(bus.iram_req), 64'd1);

        // Reset asserted mid-operand walk (counter = 1).
        drive(1'b1, 8'h40);
        tick();
        chk("t1.decode", 64'(state), 64'd1);
        chk("t1.opcode", 64'(jvm_opcode), 64'h40);
        chk("t1.req_dec", 64'(bus.iram_req), 64'd0);
        drive(1'b0, 8'h00);
        tick();
        chk("t1.params", 64'(state), 64'd2);
        chk("t1.req_par", 64'(bus.iram_req), 64'd1);
        drive(1'b1, 8'hA1);
        tick();
        chk("t1.pe1", 64'(param_even), 64'd1);
        drive(1'b0, 8'h00);
        tick();
        chk("t1.cnt1", 64'({state, param_even}), 64'({2'd2, 1'b0}));
        reset = 1'b0;
        #1;
        chk_idle("t1.rst");
        tick();
        reset = 1'b1;
        #1;
        chk("t1.refetch", 64'({state, bus.iram_req}), 64'({2'd0, 1'b1}));

        // One operand byte, chain 0x10 -> 0x55 -> end.
        acc_base = acc_cnt;
        drive(1'b1, 8'h10);
        tick();
        chk("t2.opcode", 64'(jvm_opcode), 64'h10);
        drive(1'b0, 8'h00);
        tick();
        chk("t2.params", 64'(state), 64'd2);
        drive(1'b1, 8'h2A);
        tick();
        drive(1'b0, 8'h00);
        tick();
        chk("t2.req_done", 64'(bus.iram_req), 64'd0);
        chk("t2.no_push", 64'(push_wide), 64'd0);
        tick();
        chk("t2.push", 64'(push_wide), 64'd1);
        chk("t2.iter", 64'({state, q_select}), 64'({2'd3, 1'b1}));
        chk("t2.adr0", 64'(com_adr), 64'h10);
        iter_ready = 1'b1;
        tick();
        chk("t2.push_drop", 64'(push_wide), 64'd0);
        chk("t2.adr1", 64'(com_adr), 64'h55);
        chk("t2.nodone", 64'(instr_done), 64'd0);
        tick();
        chk("t2.done", 64'(instr_done), 64'd1);
        chk("t2.fetch", 64'({state, q_select}), 64'({2'd0, 1'b0}));
`ifdef SM_PARAM_CAPTURE_EN
        chk("t2.pdata", param_data, 64'h2A);
`else
        chk("t2.pdata", param_data, 64'h0);
`endif
        iter_ready = 1'b0;
        tick();
        chk("t2.done_drop", 64'(instr_done), 64'd0);
        chk("t2.accepts", 64'(acc_cnt - acc_base), 64'd2);

        // Double WIDE prefix then 0x15 (1 operand -> 2 bytes).
        acc_base = acc_cnt;
        drive(1'b1, 8'hC4);
        tick();
        tick();
        chk("t3.wide1", 64'({state, is_wide}), 64'({2'd0, 1'b1}));
        tick();
        tick();
        chk("t3.wide2", 64'({state, is_wide}), 64'({2'd0, 1'b1}));
        drive(1'b1, 8'h15);
        tick();
        drive(1'b0, 8'h00);
        tick();
        chk("t3.params", 64'({state, is_wide}), 64'({2'd2, 1'b1}));
        drive(1'b1, 8'hB1);
        tick();
        drive(1'b0, 8'h00);
        tick();
        drive(1'b1, 8'hB2);
        tick();
        drive(1'b0, 8'h00);
        tick();
        chk("t3.req_done", 64'(bus.iram_req), 64'd0);
        tick();
        chk("t3.iter", 64'({state, push_wide, is_wide}), 64'({2'd3, 1'b1, 1'b0}));
        chk("t3.adr0", 64'(com_adr), 64'h15);
        chk("t3.accepts", 64'(acc_cnt - acc_base), 64'd5);
        iter_ready = 1'b1;
        tick();
        chk("t3.adr1", 64'(com_adr), 64'h66);
        tick();
        chk("t3.done", 64'(instr_done), 64'd1);
`ifdef SM_PARAM_CAPTURE_EN
        chk("t3.pdata", param_data, 64'hB1B2);
`else
        chk("t3.pdata", param_data, 64'h0);
`endif
        iter_ready = 1'b0;

        // Operand stalls: iram_valid low, then waiting high.
        acc_base = acc_cnt;
        drive(1'b1, 8'h40);
        tick();
        drive(1'b0, 8'h00);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4.novalid", 64'({state, param_even, bus.iram_req}), 64'({2'd2, 1'b0, 1'b1}));
        end
        waiting = 1'b1;
        drive(1'b1, 8'hC1);
        #1;
        chk("t4.wait_req", 64'(bus.iram_req), 64'd0);
        tick();
        tick();
        chk("t4.wait_hold", 64'({state, param_even}), 64'({2'd2, 1'b0}));
        waiting = 1'b0;
        tick();
        chk("t4.pe1", 64'(param_even), 64'd1);
        drive(1'b1, 8'hC2);
        tick();
        chk("t4.cnt1", 64'({param_even, bus.iram_req}), 64'({1'b0, 1'b1}));
        tick();
        drive(1'b0, 8'h00);
        tick();
        tick();
        chk("t4.push", 64'({state, push_wide}), 64'({2'd3, 1'b1}));
        chk("t4.accepts", 64'(acc_cnt - acc_base), 64'd3);
`ifdef SM_PARAM_CAPTURE_EN
        chk("t4.pdata", param_data, 64'hC1C2);
`else
        chk("t4.pdata", param_data, 64'h0);
`endif
        iter_ready = 1'b1;
        tick();
        chk("t4.done", 64'({state, instr_done}), 64'({2'd0, 1'b1}));
        iter_ready = 1'b0;

        // No operands, 3-long chain with iter_ready toggling.
        drive(1'b1, 8'h20);
        tick();
        drive(1'b0, 8'h00);
        tick();
        chk("t5.iter", 64'({state, q_select, push_wide}), 64'({2'd3, 1'b1, 1'b0}));
        chk("t5.adr0", 64'(com_adr), 64'h20);
        tick();
        chk("t5.hold0", 64'(com_adr), 64'h20);
        iter_ready = 1'b1;
        tick();
        chk("t5.adr1", 64'(com_adr), 64'h21);
        iter_ready = 1'b0;
        tick();
        chk("t5.hold1", 64'(com_adr), 64'h21);
        iter_ready = 1'b1;
        tick();
        chk("t5.adr2", 64'(com_adr), 64'h22);
        iter_ready = 1'b0;
        tick();
        chk("t5.hold2", 64'({state, com_adr, instr_done}), 64'({2'd3, 8'h22, 1'b0}));
        iter_ready = 1'b1;
        tick();
        chk("t5.done", 64'({state, instr_done}), 64'({2'd0, 1'b1}));
        chk("t5.pdata", param_data, 64'h0);
        iter_ready = 1'b0;

        // WIDE + 7 operands saturates to 8 bytes.
        acc_base = acc_cnt;
        drive(1'b1, 8'hC4);
        tick();
        drive(1'b1, 8'h30);
        tick();
        tick();
        drive(1'b0, 8'h00);
        tick();
        chk("t6.params", 64'({state, is_wide}), 64'({2'd2, 1'b1}));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hD0 + 8'(i));
            tick();
            drive(1'b0, 8'h00);
            tick();
        end
        drive(1'b1, 8'hEE);
        #1;
        chk("t6.req_done", 64'({state, bus.iram_req, push_wide}), 64'({2'd2, 1'b0, 1'b0}));
        tick();
        drive(1'b0, 8'h00);
        chk("t6.push", 64'({state, push_wide}), 64'({2'd3, 1'b1}));
        chk("t6.accepts", 64'(acc_cnt - acc_base), 64'd10);
`ifdef SM_PARAM_CAPTURE_EN
        chk("t6.pdata", param_data, 64'hD0D1D2D3D4D5D6D7);
`else
        chk("t6.pdata", param_data, 64'h0);
`endif
        tick();
        chk("t6.push_drop", 64'(push_wide), 64'd0);
        iter_ready = 1'b1;
        tick();
        chk("t6.done", 64'({state, instr_done}), 64'({2'd0, 1'b1}));
        iter_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
